// File: rtl/motion_pkg.sv
// Shared types and constants for the motion sensor conditioner.
// The optional glitch counter is enabled by defining MOTION_GLITCH_CNT_EN.
package motion_pkg;

   typedef enum logic [2:0] {
      ST_WARMUP  = 3'd0,
      ST_IDLE    = 3'd1,
      ST_QUALIFY = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_HOLD    = 3'd4
   } motion_state_t;

   localparam int unsigned CLK_HZ                  = 10_000_000;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 8;
   localparam int unsigned DEFAULT_HOLD_CYCLES     = 32'd3_000_000_000;
   localparam int unsigned DEFAULT_WARMUP_CYCLES   = CLK_HZ;
   localparam int unsigned GLITCH_CNT_W            = 8;
   localparam int unsigned CNT_W                   = 32;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; both stages clear on rst.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/motion_sensor_conditioner.sv
// PIR motion conditioner: warm-up, debounce, hold window and enable gating.
// Define MOTION_GLITCH_CNT_EN to add the saturating glitch_count output.
module motion_sensor_conditioner
   import motion_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int unsigned WARMUP_CYCLES   = DEFAULT_WARMUP_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic pir_raw,
   input  logic enable,
   output logic motion_detect,
   output logic sensor_ready
`ifdef MOTION_GLITCH_CNT_EN
   ,
   output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

   typedef logic [CNT_W-1:0] cnt_t;

   motion_state_t state;
   cnt_t          warm_cnt;
   cnt_t          deb_cnt;
   cnt_t          hold_cnt;
   logic          pir_s;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pir_raw),
      .q   (pir_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_WARMUP;
         warm_cnt      <= '0;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         motion_detect <= 1'b0;
         sensor_ready  <= 1'b0;
      end else if (state != ST_WARMUP && !enable) begin
         // Disable overrides everything once warm-up is done.
         state         <= ST_IDLE;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         motion_detect <= 1'b0;
      end else begin
         case (state)
            ST_WARMUP: begin
               if (warm_cnt == cnt_t'(WARMUP_CYCLES - 1)) begin
                  state        <= ST_IDLE;
                  sensor_ready <= 1'b1;
                  warm_cnt     <= '0;
               end else begin
                  warm_cnt <= sat_inc(warm_cnt);
               end
            end
            ST_IDLE: begin
               if (pir_s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state         <= ST_ACTIVE;
                     motion_detect <= 1'b1;
                  end else begin
                     state   <= ST_QUALIFY;
                     deb_cnt <= cnt_t'(1);
                  end
               end
            end
            ST_QUALIFY: begin
               if (!pir_s) begin
                  state   <= ST_IDLE;
                  deb_cnt <= '0;
               end else if (deb_cnt >= cnt_t'(DEBOUNCE_CYCLES)) begin
                  state         <= ST_ACTIVE;
                  deb_cnt       <= '0;
                  motion_detect <= 1'b1;
               end else begin
                  deb_cnt <= sat_inc(deb_cnt);
               end
            end
            ST_ACTIVE: begin
               if (!pir_s) begin
                  state    <= ST_HOLD;
                  hold_cnt <= '0;
               end
            end
            ST_HOLD: begin
               // A retrigger beats a hold expiry on the same edge.
               if (pir_s) begin
                  state    <= ST_ACTIVE;
                  hold_cnt <= '0;
               end else if (hold_cnt == cnt_t'(HOLD_CYCLES - 1)) begin
                  state         <= ST_IDLE;
                  hold_cnt      <= '0;
                  motion_detect <= 1'b0;
               end else begin
                  hold_cnt <= sat_inc(hold_cnt);
               end
            end
            default: begin
               state         <= ST_WARMUP;
               warm_cnt      <= '0;
               deb_cnt       <= '0;
               hold_cnt      <= '0;
               motion_detect <= 1'b0;
               sensor_ready  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MOTION_GLITCH_CNT_EN
   // A glitch is a qualification aborted by the sensor dropping, not by disable.
   always_ff @(posedge clk) begin
      if (rst) begin
         glitch_count <= '0;
      end else if (state == ST_QUALIFY && enable && !pir_s && glitch_count != '1) begin
         glitch_count <= glitch_count + GLITCH_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_motion_sensor_conditioner.sv
// Bench for motion_sensor_conditioner: directed scenarios followed by random
// segments, all checked against a run-length reference model.
module tb_motion_sensor_conditioner;
   import motion_pkg::*;

   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 10;
   localparam int unsigned WARM = 16;
   // The IDLE-entry sample plus DEB qualifying samples precede activation.
   localparam int QUAL_SAMPLES = DEB + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pir_raw = 1'b0;
   logic enable = 1'b0;
   logic motion_detect;
   logic sensor_ready;
`ifdef MOTION_GLITCH_CNT_EN
   logic [GLITCH_CNT_W-1:0] glitch_count;
`endif

   motion_sensor_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .WARMUP_CYCLES   (WARM)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pir_raw       (pir_raw),
      .enable        (enable),
      .motion_detect (motion_detect),
      .sensor_ready  (sensor_ready)
`ifdef MOTION_GLITCH_CNT_EN
      ,
      .glitch_count  (glitch_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc = -1;
   int fall_cyc = -1;
   int falls = 0;
   logic prev_md = 1'b0;
   logic [1:0] exp_q[$];

   // Reference model state: synchronizer image, warm-up age, run lengths.
   logic m_s1 = 1'b0, m_s2 = 1'b0;
   logic m_ready = 1'b0, m_md = 1'b0;
   int m_since = 0, m_run = 0, m_low = 0, m_glitch = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic p, input logic en, input logic r);
      logic ps;
      if (r) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_ready = 1'b0; m_md = 1'b0;
         m_since = 0; m_run = 0; m_low = 0; m_glitch = 0;
      end else begin
         ps = m_s2;
         m_s2 = m_s1;
         m_s1 = p;
         if (!m_ready) begin
            m_since++;
            if (m_since == WARM) m_ready = 1'b1;
         end else if (!en) begin
            m_md = 1'b0; m_run = 0; m_low = 0;
         end else if (ps) begin
            m_low = 0;
            if (!m_md) begin
               m_run++;
               if (m_run >= QUAL_SAMPLES) begin
                  m_md = 1'b1;
                  m_run = 0;
               end
            end
         end else begin
            if (!m_md && m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
            if (m_md) begin
               m_low++;
               if (m_low == HOLD + 1) begin
                  m_md = 1'b0;
                  m_low = 0;
               end
            end
         end
      end
      exp_q.push_back({m_ready, m_md});
   endtask

   task automatic tick(input logic p, input logic en, input logic r);
      logic [1:0] exp;
      pir_raw = p;
      enable = en;
      rst = r;
      @(posedge clk);
      cyc++;
      model_edge(p, en, r);
      #1;
      exp = exp_q.pop_front();
      check("sensor_ready", {31'd0, sensor_ready}, {31'd0, exp[1]});
      check("motion_detect", {31'd0, motion_detect}, {31'd0, exp[0]});
`ifdef MOTION_GLITCH_CNT_EN
      check("glitch_count", {24'd0, glitch_count}, m_glitch);
`endif
      if (!prev_md && motion_detect === 1'b1) rise_cyc = cyc;
      if (prev_md && motion_detect === 1'b0) begin
         fall_cyc = cyc;
         falls++;
      end
      prev_md = (motion_detect === 1'b1);
   endtask

   task automatic warmup_directed(input string tag);
      for (int i = 1; i <= int'(WARM); i++) begin
         tick(1'b0, 1'b1, 1'b0);
         check(tag, {31'd0, sensor_ready}, (i == int'(WARM)) ? 32'd1 : 32'd0);
      end
   endtask

   int first;
   int falls0;
   logic rv, ren, rrst;
   int rlen;

   initial begin
      // Reset and full warm-up.
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      check("reset_md", {31'd0, motion_detect}, 32'd0);
      check("reset_ready", {31'd0, sensor_ready}, 32'd0);
      warmup_directed("ready_at_warmup");
      repeat (4) tick(1'b0, 1'b1, 1'b0);

      // Sustained motion: rise and fall latency.
      rise_cyc = -1;
      first = cyc + 1;
      repeat (20) tick(1'b1, 1'b1, 1'b0);
      check("rise_latency", rise_cyc - first, 32'd6);
      first = cyc + 1;
      repeat (20) tick(1'b0, 1'b1, 1'b0);
      check("fall_latency", fall_cyc - first, 32'd12);

      // Short pulses are rejected and counted.
      rise_cyc = -1;
      repeat (5) begin
         repeat (3) tick(1'b1, 1'b1, 1'b0);
         repeat (5) tick(1'b0, 1'b1, 1'b0);
      end
      check("pulses_no_motion", rise_cyc, 32'hFFFF_FFFF);
`ifdef MOTION_GLITCH_CNT_EN
      check("pulses_glitch_count", {24'd0, glitch_count}, 32'd5);
`endif

      // Retrigger from HOLD with the hold counter at 5.
      repeat (8) tick(1'b1, 1'b1, 1'b0);
      falls0 = falls;
      repeat (6) tick(1'b0, 1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      first = cyc + 1;
      repeat (15) tick(1'b0, 1'b1, 1'b0);
      check("retrigger_single_fall", falls - falls0, 32'd1);
      check("retrigger_fall_latency", fall_cyc - first, 32'd12);

      // Disable while ACTIVE.
      repeat (10) tick(1'b1, 1'b1, 1'b0);
      check("active_before_disable", {31'd0, motion_detect}, 32'd1);
      tick(1'b1, 1'b0, 1'b0);
      check("disable_drops_md", {31'd0, motion_detect}, 32'd0);
      repeat (4) tick(1'b0, 1'b0, 1'b0);
      repeat (3) tick(1'b0, 1'b1, 1'b0);
`ifdef MOTION_GLITCH_CNT_EN
      check("disable_no_glitch", {24'd0, glitch_count}, 32'd5);
`endif

      // Reset while in HOLD.
      repeat (10) tick(1'b1, 1'b1, 1'b0);
      repeat (4) tick(1'b0, 1'b1, 1'b0);
      check("hold_before_reset", {31'd0, motion_detect}, 32'd1);
      tick(1'b0, 1'b1, 1'b1);
      check("reset_in_hold_md", {31'd0, motion_detect}, 32'd0);
      check("reset_in_hold_ready", {31'd0, sensor_ready}, 32'd0);
      warmup_directed("ready_after_rewarm");

      // Random segments of constant pir/enable, with rare resets.
      for (int seg = 0; seg < 140; seg++) begin
         rv = 1'($urandom_range(0, 1));
         ren = ($urandom_range(0, 9) != 0);
         rlen = $urandom_range(1, 14);
         for (int i = 0; i < rlen; i++) begin
            rrst = ($urandom_range(0, 299) == 0);
            tick(rv, ren, rrst);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
